// File: rtl/adder_arbiter.sv
// Purpose: round-robin arbiter that shares one N-bit add/sub unit between two requesters.
// Latency: a grant at edge t is followed by an execute cycle, and resp_valid is high from edge t+1. The next grant can come 3 cycles after the previous one.
// Backpressure: the result is held stable while resp_ready is low. Requesters must hold valid and operands until they are granted.
// Ports: clk/rst_n; req{0,1}_{valid,ready,x,y,sub} for the producer side;
//        resp_{valid,ready,id,s,c,o,z} for the tagged result and its flags.
module adder_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  input  logic         req1_sub,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_s,
  output logic         resp_c,
  output logic         resp_o,
  output logic         resp_z
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e       state_q, state_d;
  logic         last_grant_q;
  logic [N-1:0] x_q, y_q;
  logic         sub_q, id_q;
  logic         arb0, arb1;

  // On a tie, the requester that was not granted last wins.
  // last_grant_q = 1 after reset, so requester 0 wins the first tie.
  assign arb0 = req0_valid & (~req1_valid | last_grant_q);
  assign arb1 = req1_valid & (~req0_valid | ~last_grant_q);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb0 | arb1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Ready is gated with rst_n so that every output drops while reset is held.
  always_comb begin
    req0_ready = rst_n & (state_q == IDLE) & arb0;
    req1_ready = rst_n & (state_q == IDLE) & arb1;
    resp_valid = (state_q == RESP);
  end

  // Operand capture on grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      x_q          <= '0;
      y_q          <= '0;
      sub_q        <= 1'b0;
      id_q         <= 1'b0;
    end else if (state_q == IDLE && (arb0 | arb1)) begin
      last_grant_q <= arb1;
      id_q         <= arb1;
      x_q          <= arb1 ? req1_x   : req0_x;
      y_q          <= arb1 ? req1_y   : req0_y;
      sub_q        <= arb1 ? req1_sub : req0_sub;
    end
  end

  // Shared adder. Subtraction adds the two's complement of y. Because of that,
  // x - 0 produces no carry, since t = 0.
  logic [N-1:0] t_op;
  logic [N:0]   sum;
  logic         ovf;

  always_comb begin
    t_op = sub_q ? ((~y_q) + {{(N-1){1'b0}}, 1'b1}) : y_q;
    sum  = {1'b0, x_q} + {1'b0, t_op};
    ovf  = ~(x_q[N-1] ^ t_op[N-1]) & (sum[N-1] ^ x_q[N-1]);
  end

  // Result registers: loaded only in EXEC, so they stay stable through RESP and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id <= 1'b0;
      resp_s  <= '0;
      resp_c  <= 1'b0;
      resp_o  <= 1'b0;
      resp_z  <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_id <= id_q;
      resp_s  <= sum[N-1:0];
      resp_c  <= sum[N];
      resp_o  <= ovf;
      resp_z  <= (sum[N-1:0] == '0);
    end
  end

endmodule
